// File: rtl/cdu_pulse_arbiter.sv
// cdu_pulse_arbiter: round-robin drain of per-axis CDU increment counts onto
// one AGC +/- pulse pair. Define CDU_PULSE_ARB_STATS_EN to add pulse_count.
module cdu_pulse_arbiter #(
  parameter int N_CHAN    = 5,
  parameter int ACC_W     = 6,
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN   = 1,
  localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic              CLOCKH,
  input  logic              rst_n,
  input  logic              AGCZ,
  input  logic [N_CHAN-1:0] req_p,
  input  logic [N_CHAN-1:0] req_m,
  output logic              pulse_p,
  output logic              pulse_m,
  output logic [CW-1:0]     pulse_chan,
  output logic [N_CHAN-1:0] pending_nz,
  output logic [N_CHAN-1:0] ovf
`ifdef CDU_PULSE_ARB_STATS_EN
  ,
  output logic [15:0]       pulse_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_t;

  localparam int TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int SW   = ACC_W + 2;

  localparam logic signed [SW-1:0] LIM  = SW'((1 <<< (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] NLIM = -LIM;
  localparam logic signed [SW-1:0] ONE  = SW'(1);

  state_t                   r_state;
  state_t                   w_state_nx;
  logic [TW-1:0]            r_cnt;
  logic [TW-1:0]            w_cnt_nx;
  logic [CW-1:0]            r_ptr;
  logic [CW-1:0]            w_ptr_nx;
  logic                     r_pp;
  logic                     w_pp_nx;
  logic                     r_pm;
  logic                     w_pm_nx;
  logic [CW-1:0]            r_chan;
  logic [CW-1:0]            w_chan_nx;

  logic signed [ACC_W-1:0]  r_acc    [N_CHAN];
  logic signed [ACC_W-1:0]  w_acc_nx [N_CHAN];
  logic signed [SW-1:0]     w_sum    [N_CHAN];
  logic [N_CHAN-1:0]        r_ovf;
  logic [N_CHAN-1:0]        w_ovf_nx;
  logic [N_CHAN-1:0]        r_pnz;
  logic [N_CHAN-1:0]        w_pnz_nx;
  logic [N_CHAN-1:0]        w_nz;

  logic                     w_found;
  logic [CW-1:0]            w_gidx;
  logic                     w_grant;
  logic                     w_neg;

  function automatic logic [CW-1:0] rr_idx(
    input logic [CW-1:0] p,
    input int            i
  );
    int s;
    s = int'(p) + i;
    if (s >= N_CHAN) s = s - N_CHAN;
    return CW'(s);
  endfunction

  always_comb begin
    for (int c = 0; c < N_CHAN; c++) begin
      w_nz[c] = (r_acc[c] != '0);
    end
  end

  // first nonzero channel at or after the pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (!w_found && w_nz[rr_idx(r_ptr, i)]) begin
        w_found = 1'b1;
        w_gidx  = rr_idx(r_ptr, i);
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_found && !AGCZ;
  assign w_neg   = r_acc[w_gidx][ACC_W-1];

  always_comb begin
    w_ovf_nx = r_ovf;
    w_pnz_nx = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      w_sum[c] = SW'(r_acc[c]);
      if (req_p[c]) w_sum[c] = w_sum[c] + ONE;
      if (req_m[c]) w_sum[c] = w_sum[c] - ONE;
      if (w_grant && (int'(w_gidx) == c)) begin
        if (w_neg) w_sum[c] = w_sum[c] + ONE;
        else       w_sum[c] = w_sum[c] - ONE;
      end
      if (w_sum[c] > LIM) begin
        w_acc_nx[c] = LIM[ACC_W-1:0];
        w_ovf_nx[c] = 1'b1;
      end else if (w_sum[c] < NLIM) begin
        w_acc_nx[c] = NLIM[ACC_W-1:0];
        w_ovf_nx[c] = 1'b1;
      end else begin
        w_acc_nx[c] = w_sum[c][ACC_W-1:0];
      end
      if (AGCZ) begin
        w_acc_nx[c] = '0;
        w_ovf_nx[c] = 1'b0;
      end
      w_pnz_nx[c] = (w_acc_nx[c] != '0);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ptr_nx   = r_ptr;
    w_pp_nx    = r_pp;
    w_pm_nx    = r_pm;
    w_chan_nx  = r_chan;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nx = S_PULSE;
          w_cnt_nx   = '0;
          w_pp_nx    = !w_neg;
          w_pm_nx    = w_neg;
          w_chan_nx  = w_gidx;
          w_ptr_nx   = rr_idx(w_gidx, 1);
        end
      end
      S_PULSE: begin
        if (int'(r_cnt) >= PULSE_LEN - 1) begin
          w_pp_nx    = 1'b0;
          w_pm_nx    = 1'b0;
          w_cnt_nx   = '0;
          w_state_nx = (GAP_LEN > 0) ? S_GAP : S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (int'(r_cnt) >= GAP_LEN - 1) begin
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
    // zero command overrides any state; pulse_chan keeps its last value
    if (AGCZ) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_ptr_nx   = '0;
      w_pp_nx    = 1'b0;
      w_pm_nx    = 1'b0;
    end
  end

  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_pp    <= 1'b0;
      r_pm    <= 1'b0;
      r_chan  <= '0;
      r_ovf   <= '0;
      r_pnz   <= '0;
      for (int c = 0; c < N_CHAN; c++) begin
        r_acc[c] <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ptr   <= w_ptr_nx;
      r_pp    <= w_pp_nx;
      r_pm    <= w_pm_nx;
      r_chan  <= w_chan_nx;
      r_ovf   <= w_ovf_nx;
      r_pnz   <= w_pnz_nx;
      for (int c = 0; c < N_CHAN; c++) begin
        r_acc[c] <= w_acc_nx[c];
      end
    end
  end

  assign pulse_p    = r_pp;
  assign pulse_m    = r_pm;
  assign pulse_chan = r_chan;
  assign pending_nz = r_pnz;
  assign ovf        = r_ovf;

`ifdef CDU_PULSE_ARB_STATS_EN
  logic [15:0] r_pcnt;

  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (AGCZ) begin
      r_pcnt <= '0;
    end else if (w_grant) begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

  assign pulse_count = r_pcnt;
`endif

endmodule

// File: tb/tb_cdu_pulse_arbiter.sv
// tb_cdu_pulse_arbiter: directed checks of grant order, timing,
// saturation and zero command for cdu_pulse_arbiter.
module tb_cdu_pulse_arbiter;

  logic       CLOCKH = 1'b0;
  logic       rst_n  = 1'b0;
  logic       AGCZ   = 1'b0;
  logic [4:0] req_p  = '0;
  logic [4:0] req_m  = '0;
  logic       pulse_p;
  logic       pulse_m;
  logic [2:0] pulse_chan;
  logic [4:0] pending_nz;
  logic [4:0] ovf;
`ifdef CDU_PULSE_ARB_STATS_EN
  logic [15:0] pulse_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLOCKH = ~CLOCKH;

  cdu_pulse_arbiter dut (
    .CLOCKH     (CLOCKH),
    .rst_n      (rst_n),
    .AGCZ       (AGCZ),
    .req_p      (req_p),
    .req_m      (req_m),
    .pulse_p    (pulse_p),
    .pulse_m    (pulse_m),
    .pulse_chan (pulse_chan),
    .pending_nz (pending_nz),
    .ovf        (ovf)
`ifdef CDU_PULSE_ARB_STATS_EN
    ,
    .pulse_count(pulse_count)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCKH);
    @(negedge CLOCKH);
  endtask

  task automatic zero_cmd();
    AGCZ = 1'b1;
    step();
    AGCZ = 1'b0;
  endtask

  // 40 cycles of requests on every axis, then drain and count
  task automatic sat_run(input bit neg);
    int n4;
    int ntot;
    int nwrong;
    n4     = 0;
    ntot   = 0;
    nwrong = 0;
    zero_cmd();
    for (int e = 1; e <= 40; e++) begin
      req_p = neg ? 5'b00000 : 5'b11111;
      req_m = neg ? 5'b11111 : 5'b00000;
      step();
    end
    req_p = '0;
    req_m = '0;
    chk("sat_ovf", ovf, 5'b11111);
    chk("sat_pnz", pending_nz, 5'b11111);
    for (int k = 0; k < 600; k++) begin
      step();
      if (pulse_p || pulse_m) ntot++;
      if ((pulse_p || pulse_m) && pulse_chan == 3'd4) n4++;
      if (neg ? pulse_p : pulse_m) nwrong++;
    end
    chk("sat_ch4_pulses", n4, 31);
    chk("sat_total_pulses", ntot, 155);
    chk("sat_wrong_dir", nwrong, 0);
    chk("sat_drained", pending_nz, 5'b00000);
    chk("sat_ovf_sticky", ovf, 5'b11111);
    zero_cmd();
    chk("sat_ovf_clr", ovf, 5'b00000);
  endtask

  logic [16:0] ep;
  logic [16:0] em;

  initial begin
    ep = 17'h04104;
    em = 17'h00820;

    @(negedge CLOCKH);
    @(negedge CLOCKH);
    chk("rst_pp", pulse_p, 1'b0);
    chk("rst_pm", pulse_m, 1'b0);
    chk("rst_chan", pulse_chan, 3'd0);
    chk("rst_pnz", pending_nz, 5'b0);
    chk("rst_ovf", ovf, 5'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) step();

    req_p = 5'b00100;
    step();
    req_p = '0;
    chk("t1_pnz_set", pending_nz, 5'b00100);
    chk("t1_no_pulse_yet", pulse_p, 1'b0);
    step();
    chk("t1_pp", pulse_p, 1'b1);
    chk("t1_pm", pulse_m, 1'b0);
    chk("t1_chan", pulse_chan, 3'd2);
    chk("t1_pnz_clr", pending_nz, 5'b00000);
    step();
    chk("t1_pp_end", pulse_p, 1'b0);
    chk("t1_chan_hold", pulse_chan, 3'd2);

    zero_cmd();
    for (int e = 1; e <= 16; e++) begin
      req_p = (e <= 3) ? 5'b00001 : 5'b00000;
      req_m = (e <= 2) ? 5'b01000 : 5'b00000;
      step();
      req_p = '0;
      req_m = '0;
      chk($sformatf("t2_pp_e%0d", e), pulse_p, ep[e]);
      chk($sformatf("t2_pm_e%0d", e), pulse_m, em[e]);
      chk($sformatf("t2_ovl_e%0d", e), pulse_p & pulse_m, 1'b0);
      if (pulse_p || pulse_m)
        chk($sformatf("t2_chan_e%0d", e), pulse_chan, em[e] ? 3'd3 : 3'd0);
    end
    chk("t2_drained", pending_nz, 5'b0);

    zero_cmd();
    req_p = 5'b00010;
    req_m = 5'b00010;
    step();
    req_p = '0;
    req_m = '0;
    chk("t3_pnz", pending_nz, 5'b0);
    step();
    chk("t3_pp", pulse_p, 1'b0);
    chk("t3_pm", pulse_m, 1'b0);

    sat_run(1'b0);
    sat_run(1'b1);

    zero_cmd();
    for (int e = 1; e <= 8; e++) begin
      req_p = 5'b00010;
      step();
    end
    req_p = '0;
    chk("t5_pp_pre", pulse_p, 1'b1);
    chk("t5_chan_pre", pulse_chan, 3'd1);
    chk("t5_pnz_pre", pending_nz, 5'b00010);
    AGCZ  = 1'b1;
    req_p = 5'b01000;
    step();
    AGCZ  = 1'b0;
    req_p = '0;
    chk("t5_pp_z", pulse_p, 1'b0);
    chk("t5_pnz_z", pending_nz, 5'b0);
    chk("t5_ovf_z", ovf, 5'b0);
    step();
    chk("t5_discard_pp", pulse_p, 1'b0);
    chk("t5_discard_pnz", pending_nz, 5'b0);
    req_p = 5'b01001;
    step();
    req_p = '0;
    step();
    chk("t5_first_pp", pulse_p, 1'b1);
    chk("t5_first_chan", pulse_chan, 3'd0);
    step();
    step();
    step();
    chk("t5_second_pp", pulse_p, 1'b1);
    chk("t5_second_chan", pulse_chan, 3'd3);
    step();
    step();

`ifdef CDU_PULSE_ARB_STATS_EN
    zero_cmd();
    chk("st_clr", pulse_count, 16'd0);
    req_p = 5'b00001;
    req_m = 5'b00100;
    step();
    req_p = '0;
    req_m = '0;
    for (int i = 0; i < 8; i++) step();
    chk("st_two", pulse_count, 16'd2);
    zero_cmd();
    chk("st_clr2", pulse_count, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdu_pulse_arbiter.md
Name: cdu_pulse_arbiter

Overview:
- Shares one AGC counter-increment pulse pair (plus channel tag) among N_CHAN CDU read-counter axes (IMU X/Y/Z, optics shaft/trunnion).
- Each axis raises single-cycle +/- increment requests; the block accumulates each axis's net pending count and drains the counts round-robin as timed +/- pulses at the CLOCKH rate.
- Sits between the per-axis read-counter logic and the AGC interface drivers; AGCZ zeroes all pending work.

Parameters:
N_CHAN, 5, number of requesting axes (2..8)
ACC_W, 6, width of signed per-channel pending accumulator
PULSE_LEN, 1, cycles an output pulse stays high (>=1)
GAP_LEN, 1, idle cycles forced after each pulse (>=0)

Ports:
CLOCKH  input  1  51.2 kHz clock from AGC; all state on rising edge
rst_n  input  1  asynchronous active-low reset
AGCZ  input  1  zero command, active high; clears accumulators, overflow flags, pointer
req_p  input  N_CHAN  per-channel +1 request, one-cycle strobe
req_m  input  N_CHAN  per-channel -1 request, one-cycle strobe
pulse_p  output  1  positive increment pulse to AGC
pulse_m  output  1  negative increment pulse to AGC
pulse_chan  output  clog2(N_CHAN)  channel served by current pulse; valid while pulse_p|pulse_m
pending_nz  output  N_CHAN  accumulator nonzero, per channel
ovf  output  N_CHAN  sticky saturation flag, per channel

Behaviour:
- Reset (rst_n low, async): accumulators 0, ovf 0, pulse_p/pulse_m 0, pulse_chan 0, FSM IDLE, round-robin pointer 0. All outputs are registered.
- Accumulator update per edge: acc_next = acc + req_p - req_m - grant_dir.
  - grant_dir is +1/-1 if this channel is granted this edge, otherwise 0.
  - req_p and req_m together on one channel cancel.
- Saturation limit is +/-(2^(ACC_W-1)-1).
  - An update past the limit clamps to the limit and sets ovf for that channel.
  - ovf clears only on reset or AGCZ.
- FSM states: IDLE, PULSE, GAP.
  - IDLE: if any acc != 0, grant the first nonzero channel at or after the pointer, searching upward modulo N_CHAN.
    - On the same edge: pulse_p (acc>0) or pulse_m (acc<0) goes to 1, pulse_chan takes the channel, acc moves one step toward 0, pointer becomes grant+1 mod N_CHAN, state becomes PULSE.
    - Otherwise stay in IDLE.
  - PULSE: hold outputs for PULSE_LEN cycles total.
    - At the end, both pulses go to 0.
    - Next state is GAP if GAP_LEN>0, else IDLE.
    - pulse_chan holds its last value.
  - GAP: GAP_LEN cycles, then IDLE.
- Latency: a request sampled at edge k on an idle system produces a pulse high from edge k+1.
- Throughput: one pulse per PULSE_LEN+GAP_LEN+1 cycles. The IDLE decision takes one cycle between grants.
- Direction is fixed at grant. Requests arriving during PULSE/GAP only modify the accumulator and are served on later grants.
  - If a granted channel's residue flips sign during its pulse, the pulse completes unchanged.
- pulse_p and pulse_m are never high simultaneously.
- AGCZ high at an edge, in any state: accumulators and ovf clear, pulse_p/pulse_m go to 0, pointer 0, FSM IDLE. Requests in that cycle are discarded. AGCZ held high keeps everything cleared.
- pending_nz is registered from the post-update accumulators.

Optional Feature:
- Macro: CDU_PULSE_ARB_STATS_EN.
- When defined, add output pulse_count, a 16-bit wrapping count of pulses issued across all channels.
  - Increments on each grant edge; wraps 0xFFFF->0.
  - Clears on reset and AGCZ.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then req_p[2] strobed once at edge 10 -> pulse_p=1, pulse_chan=2 from edge 11 for PULSE_LEN cycles; pending_nz[2] back to 0 after edge 11.
- Three req_p on ch0 and two req_m on ch3, all pending (PULSE_LEN=1, GAP_LEN=1) -> pulses alternate: ch0+, ch3-, ch0+, ch3-, ch0+; grant edges 3 cycles apart; no overlap of pulse_p and pulse_m.
- req_p[1] and req_m[1] in the same cycle -> acc stays 0, no pulse, pending_nz[1]=0.
- 40 consecutive req_p on ch4 with ACC_W=6, pulses blocked by continuous traffic -> acc clamps at +31, ovf[4]=1 and stays 1 until AGCZ.
- AGCZ asserted mid-PULSE with ch1 acc=+5 -> pulse_p low next edge, acc=0, ovf=0, FSM IDLE; next request on ch0 granted first.
- CDU_PULSE_ARB_STATS_EN defined: 70000 pulses issued -> pulse_count=4464 (70000 mod 65536); AGCZ -> 0.
